reward_fetch: RTL and testbench
===============================

Name: reward_fetch

Overview:
- Front-end stage that sits directly upstream of the reward-table ROM in the Q-learning datapath.
- Accepts a (state, action) request over a valid/ready handshake and computes the flat ROM address.
- Drives the ROM's address and read strobe, then captures the reward after the ROM's one-cycle registered latency.
- Presents the reward to the Q-update stage over a valid/ready handshake, holding it until consumed.

Parameters:
- S_WIDTH, 4, state index width
- A_WIDTH, 2, action index width
- NUM_STATES, 16, legal states 0..NUM_STATES-1
- NUM_ACTIONS, 4, legal actions 0..NUM_ACTIONS-1
- ADDR_WIDTH, 8, ROM address width
- DATA_WIDTH, 8, reward width, two's complement
- OOR_REWARD, 8'hF7, reward substituted for out-of-range requests (-9)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready
- i_state  in  S_WIDTH  current state
- i_action  in  A_WIDTH  chosen action
- o_rt_addr  out  ADDR_WIDTH  ROM address
- o_rt_read  out  1  ROM read strobe
- i_rt_data  in  DATA_WIDTH  ROM registered data
- o_rsp_valid  out  1  reward valid
- i_rsp_ready  in  1  consumer ready
- o_reward  out  DATA_WIDTH  reward value
- o_oor  out  1  response came from an out-of-range request
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values: o_rt_addr=0, o_rt_read=0, o_rsp_valid=0, o_reward=0, o_oor=0, FSM=IDLE.
- Reset mid-operation: any in-flight request is dropped with no response.
- Requests during reset: ignored while i_rst=1.
- o_req_ready and o_busy: o_req_ready=1 iff FSM==IDLE and i_rst=0. o_busy = !(FSM==IDLE).
- Outstanding requests: at most one.
- FSM states: IDLE -> ISSUE -> CAPT -> RESP -> IDLE.
- IDLE:
  - On i_req_valid && o_req_ready, latch state/action and compute addr = state*NUM_ACTIONS + action, truncated to ADDR_WIDTH.
  - Register addr into o_rt_addr.
  - Compute oor = (state>=NUM_STATES) || (action>=NUM_ACTIONS). Go to ISSUE.
- ISSUE: o_rt_read=1 for exactly this cycle, only if !oor. o_rt_addr stable. Go to CAPT.
- CAPT:
  - i_rt_data is valid this cycle.
  - At the clock edge: o_reward <= oor ? OOR_REWARD : i_rt_data; o_oor <= oor; o_rsp_valid <= 1. Go to RESP.
- RESP:
  - o_rsp_valid=1. o_reward and o_oor held stable until i_rsp_ready=1.
  - On that handshake edge, o_rsp_valid <= 0 and FSM goes to IDLE.
  - A handshake in the same cycle as a new i_req_valid does not accept the request; it is accepted next cycle.
- Latency: accept edge (cycle 0) to o_rsp_valid high = 3 cycles (valid in cycle 3). Minimum issue interval is 4 cycles.
- Out-of-range requests: the ROM is never strobed (o_rt_read stays 0). Timing is identical to in-range requests.
- o_rt_addr: holds its last value between requests; it is not cleared.
- Input stability: i_state/i_action need only be stable in the accept cycle.
- Backpressure: i_rsp_ready low for any number of cycles stalls in RESP with no data change.

Optional Feature:
- Macro: REWARD_ACC_EN
- Defined:
  - Adds parameter ACC_WIDTH (default 16) and ports i_acc_clr (in, 1) and o_acc (out, ACC_WIDTH, signed).
  - On every response handshake, o_acc <= o_acc + sign-extended o_reward, saturating at the signed max/min of ACC_WIDTH.
  - i_acc_clr=1 sets o_acc to 0 next edge. Clear has priority over a simultaneous add. Reset sets o_acc=0.
- Not defined: parameter and ports are absent; no accumulator logic.

Test Plan:
- Reset then idle -> o_req_ready=1, o_rsp_valid=0, o_rt_read=0, o_reward=0 for 5 cycles.
- Request state=2, action=1, ROM model returns 8'h05 at addr 9, i_rsp_ready=1 -> o_rt_addr=9; o_rt_read high exactly one cycle (cycle 1); o_rsp_valid rises in cycle 3 with o_reward=8'h05, o_oor=0.
- Request state=15, action=3 -> o_rt_addr=8'd63; response carries ROM data for addr 63.
- Request action=3 with NUM_ACTIONS=3 -> o_rt_read never asserts; o_reward=8'hF7, o_oor=1, still 3-cycle latency.
- Hold i_rsp_ready=0 for 10 cycles with i_req_valid=1 -> o_reward stable, o_req_ready=0; release ready -> next request accepted one cycle after the handshake.
- Assert i_rst in CAPT state -> next cycle FSM IDLE, o_rsp_valid=0, no response emitted.
- (REWARD_ACC_EN) Rewards +5, -9, +3 consumed -> o_acc = -1. Raise i_acc_clr together with a handshake -> o_acc=0.

Source files
------------

// File: rtl/reward_fetch.sv
// reward_fetch: front end of the reward-table ROM in the Q-learning datapath.
// It takes one (state, action) request at a time and builds the flat ROM address.
// It strobes the ROM and captures the registered read data one cycle later.
// It then offers the reward downstream and holds it until the consumer takes it.
// Requests whose state or action is out of range never touch the ROM. They still
// get a response with OOR_REWARD and o_oor set, on the same timing.
// Optional build macro REWARD_ACC_EN adds a saturating signed running total of
// every consumed reward (o_acc, cleared by i_acc_clr).
module reward_fetch #(
  parameter int unsigned S_WIDTH     = 4,
  parameter int unsigned A_WIDTH     = 2,
  parameter int unsigned NUM_STATES  = 16,
  parameter int unsigned NUM_ACTIONS = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] OOR_REWARD = 8'hF7
`ifdef REWARD_ACC_EN
  ,
  parameter int unsigned ACC_WIDTH   = 16
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [S_WIDTH-1:0]    i_state,
  input  logic [A_WIDTH-1:0]    i_action,
  output logic [ADDR_WIDTH-1:0] o_rt_addr,
  output logic                  o_rt_read,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_reward,
  output logic                  o_oor,
  output logic                  o_busy
`ifdef REWARD_ACC_EN
  ,
  input  logic                  i_acc_clr,
  output logic signed [ACC_WIDTH-1:0] o_acc
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                  state_r;
  logic                    oor_r;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic                    oor_s;
  logic                    accept_s;

  // Flat ROM address and range check for the request currently on the inputs
  always_comb begin
    addr_s = ADDR_WIDTH'(i_state) * ADDR_WIDTH'(NUM_ACTIONS) + ADDR_WIDTH'(i_action);
    oor_s  = (32'(i_state) >= NUM_STATES) || (32'(i_action) >= NUM_ACTIONS);
  end

  // Ready only in IDLE and never while reset is held, so requests during reset are dropped
  assign o_req_ready = (state_r == ST_IDLE) && !i_rst;
  assign o_busy      = (state_r != ST_IDLE);
  assign accept_s    = i_req_valid && o_req_ready;

  // Request sequencer: accept, strobe ROM, capture data, hold response until consumed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      oor_r       <= 1'b0;
      o_rt_addr   <= '0;
      o_rt_read   <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_reward    <= '0;
      o_oor       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            o_rt_addr <= addr_s;
            oor_r     <= oor_s;
            // Strobe is registered here so it is high for exactly the ISSUE cycle
            o_rt_read <= !oor_s;
            state_r   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_rt_read <= 1'b0;
          state_r   <= ST_CAPT;
        end
        ST_CAPT: begin
          // ROM registered data is valid now; out-of-range requests get the fixed reward
          o_reward    <= oor_r ? OOR_REWARD : i_rt_data;
          o_oor       <= oor_r;
          o_rsp_valid <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          o_rt_read   <= 1'b0;
          o_rsp_valid <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef REWARD_ACC_EN
  logic                    rsp_hs_s;
  logic signed [ACC_WIDTH:0] acc_sum_s;

  // One guard bit catches signed overflow of the running total
  always_comb begin
    rsp_hs_s  = (state_r == ST_RESP) && i_rsp_ready;
    acc_sum_s = {o_acc[ACC_WIDTH-1], o_acc} + (ACC_WIDTH+1)'(signed'(o_reward));
  end

  // Saturating accumulator of consumed rewards; clear wins over a same-cycle add
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_acc <= '0;
    end else if (i_acc_clr) begin
      o_acc <= '0;
    end else if (rsp_hs_s) begin
      if (acc_sum_s[ACC_WIDTH] != acc_sum_s[ACC_WIDTH-1]) begin
        o_acc <= acc_sum_s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        o_acc <= acc_sum_s[ACC_WIDTH-1:0];
      end
    end else begin
      o_acc <= o_acc;
    end
  end
`endif

endmodule

// File: tb/tb_reward_fetch.sv
// Bench for reward_fetch: two instances (NUM_ACTIONS=4 and NUM_ACTIONS=3) with
// registered ROM models, a vector table plus hand-written multi-cycle sequences.
module tb_reward_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_a, req_valid_b;
  logic [3:0] state;
  logic [1:0] action;
  logic       rsp_ready;

  logic       req_ready_a, rt_read_a, rsp_valid_a, oor_a, busy_a;
  logic [7:0] rt_addr_a, rt_data_a, reward_a;
  logic       req_ready_b, rt_read_b, rsp_valid_b, oor_b, busy_b;
  logic [7:0] rt_addr_b, rt_data_b, reward_b;
`ifdef REWARD_ACC_EN
  logic              acc_clr;
  logic signed [15:0] acc_a, acc_b;
`endif

  logic       sel;
  logic       cur_req_ready, cur_rt_read, cur_rsp_valid, cur_oor, cur_busy;
  logic [7:0] cur_rt_addr, cur_reward;

  logic [7:0] rom [256];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         sel;
    logic [3:0] st;
    logic [1:0] act;
    logic [7:0] exp_addr;
    logic [7:0] exp_reward;
    bit         exp_oor;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  reward_fetch u_dut_a (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid_a),
    .o_req_ready (req_ready_a),
    .i_state     (state),
    .i_action    (action),
    .o_rt_addr   (rt_addr_a),
    .o_rt_read   (rt_read_a),
    .i_rt_data   (rt_data_a),
    .o_rsp_valid (rsp_valid_a),
    .i_rsp_ready (rsp_ready),
    .o_reward    (reward_a),
    .o_oor       (oor_a),
    .o_busy      (busy_a)
`ifdef REWARD_ACC_EN
    , .i_acc_clr (acc_clr),
    .o_acc       (acc_a)
`endif
  );

  reward_fetch #(.NUM_ACTIONS(3)) u_dut_b (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid_b),
    .o_req_ready (req_ready_b),
    .i_state     (state),
    .i_action    (action),
    .o_rt_addr   (rt_addr_b),
    .o_rt_read   (rt_read_b),
    .i_rt_data   (rt_data_b),
    .o_rsp_valid (rsp_valid_b),
    .i_rsp_ready (rsp_ready),
    .o_reward    (reward_b),
    .o_oor       (oor_b),
    .o_busy      (busy_b)
`ifdef REWARD_ACC_EN
    , .i_acc_clr (acc_clr),
    .o_acc       (acc_b)
`endif
  );

  // Registered ROM models: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (rt_read_a) rt_data_a <= rom[rt_addr_a];
    if (rt_read_b) rt_data_b <= rom[rt_addr_b];
  end

  // Observe whichever instance the current vector targets
  always_comb begin
    cur_req_ready = sel ? req_ready_b : req_ready_a;
    cur_rt_read   = sel ? rt_read_b   : rt_read_a;
    cur_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    cur_oor       = sel ? oor_b       : oor_a;
    cur_busy      = sel ? busy_b      : busy_a;
    cur_rt_addr   = sel ? rt_addr_b   : rt_addr_a;
    cur_reward    = sel ? reward_b    : reward_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full transaction with the consumer always ready
  task automatic run_vec(input vec_t v, input bit clr_on_hs);
    int reads;
    sel = v.sel;
    @(negedge clk);
    check("ready_before", 32'(cur_req_ready), 32'd1);
    state  = v.st;
    action = v.act;
    if (v.sel) req_valid_b = 1'b1;
    else       req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    state  = ~v.st;
    action = ~v.act;
    reads  = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (cur_rt_read) reads++;
      if (c == 1) begin
        check("rt_addr", 32'(cur_rt_addr), 32'(v.exp_addr));
        check("rt_read_c1", 32'(cur_rt_read), 32'(!v.exp_oor));
        check("busy", 32'(cur_busy), 32'd1);
      end
      if (c < 3) begin
        check("rsp_valid_early", 32'(cur_rsp_valid), 32'd0);
      end else begin
        check("rsp_valid_c3", 32'(cur_rsp_valid), 32'd1);
        check("reward", 32'(cur_reward), 32'(v.exp_reward));
        check("oor", 32'(cur_oor), 32'(v.exp_oor));
      end
    end
    check("read_count", 32'(reads), v.exp_oor ? 32'd0 : 32'd1);
`ifdef REWARD_ACC_EN
    acc_clr = clr_on_hs;
`endif
    @(posedge clk);
    #1;
`ifdef REWARD_ACC_EN
    acc_clr = 1'b0;
`endif
    @(negedge clk);
    check("rsp_valid_after", 32'(cur_rsp_valid), 32'd0);
    check("busy_after", 32'(cur_busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 3 + 1);
    rom[9] = 8'h05;
    rom[1] = 8'h03;

    vecs[0] = '{1'b0, 4'd2,  2'd1, 8'd9,  8'h05, 1'b0};
    vecs[1] = '{1'b0, 4'd15, 2'd3, 8'd63, 8'hBE, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  2'd0, 8'd0,  8'h01, 1'b0};
    vecs[3] = '{1'b0, 4'd7,  2'd2, 8'd30, 8'h5B, 1'b0};
    vecs[4] = '{1'b0, 4'd10, 2'd0, 8'd40, 8'h79, 1'b0};
    vecs[5] = '{1'b1, 4'd1,  2'd3, 8'd6,  8'hF7, 1'b1};
    vecs[6] = '{1'b1, 4'd4,  2'd2, 8'd14, 8'h2B, 1'b0};
    vecs[7] = '{1'b1, 4'd15, 2'd3, 8'd48, 8'hF7, 1'b1};
    vecs[8] = '{1'b1, 4'd3,  2'd0, 8'd9,  8'h05, 1'b0};

    rst = 1'b1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    state = 4'd0;
    action = 2'd0;
    rsp_ready = 1'b1;
    sel = 1'b0;
`ifdef REWARD_ACC_EN
    acc_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(req_ready_a), 32'd1);
      check("idle_rsp_valid", 32'(rsp_valid_a), 32'd0);
      check("idle_rt_read", 32'(rt_read_a), 32'd0);
      check("idle_reward", 32'(reward_a), 32'd0);
    end
    check("idle_oor", 32'(oor_a), 32'd0);
    check("idle_addr", 32'(rt_addr_a), 32'd0);
    check("idle_busy", 32'(busy_a), 32'd0);
`ifdef REWARD_ACC_EN
    check("acc_reset", {16'h0, acc_a}, 32'h0);
`endif

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

    // Backpressure: consumer stalls 10 cycles while a new request waits
    sel = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    state = 4'd2;
    action = 2'd1;
    req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    state = 4'd7;
    action = 2'd2;
    repeat (3) @(negedge clk);
    check("bp_rsp_valid", 32'(rsp_valid_a), 32'd1);
    check("bp_reward", 32'(reward_a), 32'h05);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_reward", 32'(reward_a), 32'h05);
      check("bp_hold_valid", 32'(rsp_valid_a), 32'd1);
      check("bp_hold_ready", 32'(req_ready_a), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_busy", 32'(busy_a), 32'd0);
    check("bp_hs_ready", 32'(req_ready_a), 32'd1);
    check("bp_hs_valid", 32'(rsp_valid_a), 32'd0);
    @(negedge clk);
    req_valid_a = 1'b0;
    check("bp_next_busy", 32'(busy_a), 32'd1);
    check("bp_next_addr", 32'(rt_addr_a), 32'd30);
    repeat (2) @(negedge clk);
    check("bp_next_valid", 32'(rsp_valid_a), 32'd1);
    check("bp_next_reward", 32'(reward_a), 32'h5B);
    @(negedge clk);
    check("bp_next_done", 32'(busy_a), 32'd0);

    // Reset while in CAPT drops the request; requests during reset are ignored
    @(negedge clk);
    state = 4'd15;
    action = 2'd3;
    req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid_a = 1'b1;
    @(negedge clk);
    check("capt_busy", 32'(busy_a), 32'd1);
    check("rst_ready_low", 32'(req_ready_a), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(rsp_valid_a), 32'd0);
    check("rst_reward", 32'(reward_a), 32'd0);
    check("rst_addr", 32'(rt_addr_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(rsp_valid_a), 32'd0);
      check("post_rst_busy", 32'(busy_a), 32'd0);
      check("post_rst_ready", 32'(req_ready_a), 32'd1);
    end

`ifdef REWARD_ACC_EN
    // Accumulator: +5, -9, +3 gives -1; clear alongside a handshake wins
    @(negedge clk);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    @(negedge clk);
    check("acc_clr", {16'h0, acc_b}, 32'h0);
    run_vec('{1'b1, 4'd3, 2'd0, 8'd9, 8'h05, 1'b0}, 1'b0);
    run_vec('{1'b1, 4'd1, 2'd3, 8'd6, 8'hF7, 1'b1}, 1'b0);
    run_vec('{1'b1, 4'd0, 2'd1, 8'd1, 8'h03, 1'b0}, 1'b0);
    check("acc_sum", {16'h0, acc_b}, 32'h0000FFFF);
    run_vec('{1'b1, 4'd3, 2'd0, 8'd9, 8'h05, 1'b0}, 1'b1);
    check("acc_clr_hs", {16'h0, acc_b}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
